// File: rtl/busca_instrucao.sv
// Instruction fetch stage of the nRisk-8bits core: owns PC and IR, fetches over a
// req/ack memory port and hands IR to the decoder with a valid/ready handshake.
module busca_instrucao #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [3:0]        comando,
  output logic [3:0]        operando,
  output logic [ADDR_W-1:0] pc_atual,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              J,
  input  logic              Br,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] alvo,
  output logic              erro_busca
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {OCIOSO, BUSCA, RETENTA, ENTREGA} estado_t;

  estado_t           estado;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      pc          <= PC0;
      ir          <= '0;
      pc_atual    <= PC0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      erro_busca  <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          estado  <= BUSCA;
          mem_req <= 1'b1;
        end
        BUSCA: begin
          // an ack landing on the timeout cycle still wins
          if (mem_ack) begin
            ir          <= mem_data;
            pc_atual    <= pc;
            pc          <= pc + 1'b1;
            cnt         <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
            estado      <= ENTREGA;
          end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
            erro_busca <= 1'b1;
            cnt        <= '0;
            mem_req    <= 1'b0;
            estado     <= RETENTA;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        RETENTA: begin
          mem_req <= 1'b1;
          estado  <= BUSCA;
        end
        ENTREGA: begin
          if (instr_ready) begin
            // pc already points past this instruction; only a taken redirect moves it
            if (J | (Br & br_taken)) pc <= alvo;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            estado      <= BUSCA;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign mem_addr = pc;
  assign comando  = ir[DATA_W-1 -: 4];
  assign operando = ir[3:0];

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed fetch table, timeout/reset sequences,
// then random traffic against a transaction-level reference model.
module tb_busca_instrucao;
  logic       clock = 1'b0;
  logic       reset;
  logic       mem_req, mem_ack, instr_valid, instr_ready, J, Br, br_taken, erro_busca;
  logic [7:0] mem_addr, mem_data, pc_atual, alvo;
  logic [3:0] comando, operando;

  always #5 clock = ~clock;

  busca_instrucao #(.ADDR_W(8), .DATA_W(8), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .comando(comando), .operando(operando),
    .pc_atual(pc_atual), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .J(J), .Br(Br), .br_taken(br_taken), .alvo(alvo), .erro_busca(erro_busca)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    mem_ack = 0; mem_data = 8'h00; instr_ready = 0;
    J = 0; Br = 0; br_taken = 0; alvo = 8'h00;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      if (mem_req) break;
      tick();
    end
    chk("wait_req", mem_req, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         ack_dly;
    int         rdy_dly;
    logic       j, br, bt;
    logic [7:0] alvo;
    logic [7:0] e_addr;
    logic [3:0] e_cmd, e_opr;
  } vec_t;

  vec_t tbl[9];

  task automatic run_vec(input vec_t v);
    logic [7:0] nxt;
    wait_req();
    chk("fetch_addr", mem_addr, v.e_addr);
    for (int i = 0; i < v.ack_dly; i++) begin
      tick();
      chk("req_held", mem_req, 1);
      chk("addr_held", mem_addr, v.e_addr);
    end
    mem_ack = 1; mem_data = v.data;
    tick();
    mem_ack = 0; mem_data = 8'hFF;
    chk("valid_after_ack", instr_valid, 1);
    chk("req_after_ack", mem_req, 0);
    chk("comando", comando, v.e_cmd);
    chk("operando", operando, v.e_opr);
    chk("pc_atual", pc_atual, v.e_addr);
    chk("erro_clear", erro_busca, 0);
    for (int i = 0; i < v.rdy_dly; i++) begin
      // noise that must be ignored while not accepted
      J = 1; alvo = 8'hEE; mem_ack = 1; mem_data = 8'h99;
      tick();
      idle_in();
      chk("valid_hold", instr_valid, 1);
      chk("req_low_hold", mem_req, 0);
      chk("cmd_hold", comando, v.e_cmd);
      chk("opr_hold", operando, v.e_opr);
    end
    instr_ready = 1; J = v.j; Br = v.br; br_taken = v.bt; alvo = v.alvo;
    tick();
    idle_in();
    nxt = (v.j | (v.br & v.bt)) ? v.alvo : v.e_addr + 8'd1;
    chk("valid_after_acc", instr_valid, 0);
    chk("req_after_acc", mem_req, 1);
    chk("next_addr", mem_addr, nxt);
  endtask

  // reference model state
  logic [7:0] m_pc, m_ir, m_pca;
  logic       m_req, m_valid, m_err, m_gap;
  int         m_wait;

  initial begin
    tbl[0] = '{8'h3A,  1, 0, 0, 0, 0, 8'h00, 8'h00, 4'h3, 4'hA};
    tbl[1] = '{8'h5C,  0, 5, 1, 0, 0, 8'h40, 8'h01, 4'h5, 4'hC};
    tbl[2] = '{8'h71,  2, 0, 0, 1, 0, 8'h90, 8'h40, 4'h7, 4'h1};
    tbl[3] = '{8'h9F,  0, 1, 0, 1, 1, 8'hFF, 8'h41, 4'h9, 4'hF};
    tbl[4] = '{8'hE2,  3, 0, 0, 0, 0, 8'h55, 8'hFF, 4'hE, 4'h2};
    tbl[5] = '{8'h04,  0, 0, 1, 0, 0, 8'h20, 8'h00, 4'h0, 4'h4};
    tbl[6] = '{8'hB7, 14, 0, 1, 1, 0, 8'h33, 8'h20, 4'hB, 4'h7};
    tbl[7] = '{8'h11,  0, 2, 0, 0, 0, 8'h00, 8'h33, 4'h1, 4'h1};
    tbl[8] = '{8'h22,  1, 0, 0, 1, 1, 8'h7E, 8'h34, 4'h2, 4'h2};

    idle_in();
    reset = 1;
    tick(); tick();
    chk("rst_req", mem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", erro_busca, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pca", pc_atual, 0);
    chk("rst_cmd", comando, 0);
    chk("rst_opr", operando, 0);
    reset = 0;

    for (int k = 0; k < 9; k++) run_vec(tbl[k]);

    // timeout: 15 request cycles, one idle cycle, retry same address
    wait_req();
    chk("to_addr", mem_addr, 8'h7E);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("to_req_high", mem_req, 1);
      chk("to_no_err_yet", erro_busca, 0);
    end
    tick();
    chk("to_req_low", mem_req, 0);
    chk("to_err", erro_busca, 1);
    chk("to_valid", instr_valid, 0);
    tick();
    chk("retry_req", mem_req, 1);
    chk("retry_addr", mem_addr, 8'h7E);
    mem_ack = 1; mem_data = 8'hD5;
    tick();
    idle_in();
    chk("retry_cmd", comando, 4'hD);
    chk("retry_pca", pc_atual, 8'h7E);
    instr_ready = 1;
    tick();
    idle_in();
    chk("err_sticky", erro_busca, 1);
    chk("after_retry_addr", mem_addr, 8'h7F);

    // reset while waiting for ack; an ack in the following idle cycle is ignored
    wait_req();
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; mem_ack = 1; mem_data = 8'hC3;
    chk("mrst_req", mem_req, 0);
    chk("mrst_valid", instr_valid, 0);
    chk("mrst_err", erro_busca, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_pca", pc_atual, 0);
    chk("mrst_cmd", comando, 0);
    tick();
    mem_ack = 0;
    chk("mrst_req_again", mem_req, 1);
    chk("mrst_ack_ignored", instr_valid, 0);
    chk("mrst_fetch_addr", mem_addr, 0);
    mem_ack = 1; mem_data = 8'h6B;
    tick();
    idle_in();
    chk("mrst_cmd2", comando, 4'h6);
    chk("mrst_opr2", operando, 4'hB);
    chk("mrst_pca2", pc_atual, 0);

    // random traffic vs transaction model
    reset = 1;
    tick();
    reset = 0;
    m_pc = 0; m_ir = 0; m_pca = 0; m_req = 0; m_valid = 0; m_err = 0; m_gap = 1; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("r_req", mem_req, m_req);
      chk("r_valid", instr_valid, m_valid);
      chk("r_err", erro_busca, m_err);
      if (m_req) chk("r_addr", mem_addr, m_pc);
      if (m_valid) begin
        chk("r_cmd", comando, m_ir[7:4]);
        chk("r_opr", operando, m_ir[3:0]);
        chk("r_pca", pc_atual, m_pca);
      end
      mem_ack     = ($urandom_range(0, 3) == 0);
      mem_data    = 8'($urandom);
      instr_ready = ($urandom_range(0, 2) == 0);
      J           = ($urandom_range(0, 3) == 0);
      Br          = ($urandom_range(0, 2) == 0);
      br_taken    = 1'($urandom);
      alvo        = 8'($urandom);
      if (m_req) begin
        if (mem_ack) begin
          m_ir = mem_data; m_pca = m_pc; m_pc = m_pc + 8'd1;
          m_req = 0; m_valid = 1; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == 15) begin
            m_err = 1; m_req = 0; m_gap = 1; m_wait = 0;
          end
        end
      end else if (m_valid) begin
        if (instr_ready) begin
          if (J || (Br && br_taken)) m_pc = alvo;
          m_valid = 0; m_req = 1;
        end
      end else if (m_gap) begin
        m_gap = 0; m_req = 1;
      end
      tick();
    end
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
